// File: rtl/mem_ctrl_pkg.sv
// Shared types for the byte-serialising RAM controller.
// Holds the access-width encodings, the controller state enum and the width-to-byte-count helper.
// No logic of its own; imported by mem_ctrl.
package mem_ctrl_pkg;

  localparam logic [1:0] WIDTH_B = 2'b00;
  localparam logic [1:0] WIDTH_H = 2'b01;
  localparam logic [1:0] WIDTH_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IF_RD = 2'd1,
    LS_RD = 2'd2,
    LS_WR = 2'd3
  } state_e;

  // Number of bytes moved for a given width code; the spare code 11 behaves as a word.
  function automatic logic [2:0] width_nbytes(input logic [1:0] w);
    case (w)
      WIDTH_B: return 3'd1;
      WIDTH_H: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Sole master of the byte-wide RAM: arbitrates fetch vs load/store and serialises each access LSB-first.
// Latency: N-byte read done in cycle N+1, N-byte write done in cycle N (acceptance = cycle 0).
// Backpressure: requesters hold valid until done; rdy_in=0 freezes everything and re-issues a lost read byte.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  clear_in,
  input  logic                  if_valid_in,
  input  logic [31:0]           if_addr_in,
  output logic                  if_done_out,
  output logic [31:0]           if_data_out,
  input  logic                  ls_valid_in,
  input  logic                  ls_wr_in,
  input  logic [1:0]            ls_width_in,
  input  logic [31:0]           ls_addr_in,
  input  logic [31:0]           ls_wdata_in,
  output logic                  ls_done_out,
  output logic [31:0]           ls_rdata_out,
  output logic                  ram_en_out,
  output logic                  ram_r_nw_out,
  output logic [ADDR_WIDTH-1:0] ram_a_out,
  output logic [7:0]            ram_d_out,
  input  logic [7:0]            ram_d_in
);

  state_e      state_q, state_d;
  // Reads: index of the oldest uncaptured byte. Writes: index of the next byte to issue.
  logic [2:0]  cnt_q, cnt_d;
  // A read byte was issued last cycle and its data is on ram_d_in now.
  logic        infl_q, infl_d;
  logic [2:0]  n_q, n_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] lanes_q, lanes_d;
  logic        if_done_q, if_done_d;
  logic        ls_done_q, ls_done_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] ls_rdata_q, ls_rdata_d;

  logic        ls_take, if_take;
  logic        issue, issue_wr;
  logic [31:0] issue_base;
  logic [2:0]  issue_k;
  logic [7:0]  wbyte;
  logic [31:0] lanes_fin;
  logic [31:0] a_sum;
  logic [2:0]  rd_next;
  logic        unused_addr_hi;

  // Done pulses are held while stalled and only shown on a ready cycle; fetch done is hidden under a flush.
  assign if_done_out  = if_done_q & rdy_in & ~clear_in;
  assign ls_done_out  = ls_done_q & rdy_in;
  assign if_data_out  = if_data_q;
  assign ls_rdata_out = ls_rdata_q;

  // Load/store wins; neither side is re-accepted while its own done is showing.
  assign ls_take = (state_q == IDLE) && rdy_in && !rst_in && ls_valid_in && !ls_done_out;
  assign if_take = (state_q == IDLE) && rdy_in && !rst_in && !ls_take &&
                   if_valid_in && !if_done_out && !clear_in;

  // After a stall the in-flight byte was dropped, so the oldest uncaptured byte is issued again.
  assign rd_next = cnt_q + {2'b00, infl_q};

  // Merge the byte arriving this cycle into its lane.
  always_comb begin
    lanes_fin = lanes_q;
    for (int i = 0; i < 4; i++) begin
      if (cnt_q == 3'(i)) lanes_fin[8*i +: 8] = ram_d_in;
    end
  end

  // Next-state, byte issue and completion logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    infl_d     = infl_q;
    n_d        = n_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    lanes_d    = lanes_q;
    if_data_d  = if_data_q;
    ls_rdata_d = ls_rdata_q;
    if_done_d  = rdy_in ? 1'b0 : if_done_q;
    ls_done_d  = rdy_in ? 1'b0 : ls_done_q;
    issue      = 1'b0;
    issue_wr   = 1'b0;
    issue_base = addr_q;
    issue_k    = 3'd0;
    wbyte      = 8'h00;

    if (!rdy_in) begin
      // Frozen: only the in-flight read byte is forgotten, its capture cycle is lost.
      infl_d = 1'b0;
    end else if (!rst_in) begin
      case (state_q)
        IDLE: begin
          if (ls_take) begin
            n_d        = width_nbytes(ls_width_in);
            addr_d     = ls_addr_in;
            wdata_d    = ls_wdata_in;
            lanes_d    = '0;
            issue      = 1'b1;
            issue_base = ls_addr_in;
            if (ls_wr_in) begin
              issue_wr = 1'b1;
              wbyte    = ls_wdata_in[7:0];
              if (width_nbytes(ls_width_in) == 3'd1) begin
                ls_done_d = 1'b1;
              end else begin
                state_d = LS_WR;
                cnt_d   = 3'd1;
              end
            end else begin
              state_d = LS_RD;
              cnt_d   = 3'd0;
              infl_d  = 1'b1;
            end
          end else if (if_take) begin
            n_d        = 3'd4;
            addr_d     = if_addr_in;
            lanes_d    = '0;
            issue      = 1'b1;
            issue_base = if_addr_in;
            state_d    = IF_RD;
            cnt_d      = 3'd0;
            infl_d     = 1'b1;
          end
        end

        IF_RD, LS_RD: begin
          if (state_q == IF_RD && clear_in) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
            infl_d  = 1'b0;
          end else if (infl_q && cnt_q == n_q - 3'd1) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
            infl_d  = 1'b0;
            if (state_q == IF_RD) begin
              if_done_d = 1'b1;
              if_data_d = lanes_fin;
            end else begin
              ls_done_d  = 1'b1;
              ls_rdata_d = lanes_fin;
            end
          end else begin
            if (infl_q) begin
              lanes_d = lanes_fin;
              cnt_d   = cnt_q + 3'd1;
            end
            issue   = 1'b1;
            issue_k = rd_next;
            infl_d  = 1'b1;
          end
        end

        LS_WR: begin
          issue    = 1'b1;
          issue_wr = 1'b1;
          issue_k  = cnt_q;
          for (int i = 0; i < 4; i++) begin
            if (cnt_q == 3'(i)) wbyte = wdata_q[8*i +: 8];
          end
          if (cnt_q == n_q - 3'd1) begin
            state_d   = IDLE;
            cnt_d     = 3'd0;
            ls_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // RAM address wraps within the RAM's byte space.
  assign a_sum          = issue_base + {29'd0, issue_k};
  assign unused_addr_hi = ^a_sum[31:ADDR_WIDTH];
  assign ram_en_out     = issue;
  assign ram_r_nw_out   = ~issue_wr;
  assign ram_a_out      = issue ? a_sum[ADDR_WIDTH-1:0] : '0;
  assign ram_d_out      = wbyte;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      infl_q     <= 1'b0;
      n_q        <= 3'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      lanes_q    <= '0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
      if_data_q  <= '0;
      ls_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      infl_q     <= infl_d;
      n_q        <= n_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      lanes_q    <= lanes_d;
      if_done_q  <= if_done_d;
      ls_done_q  <= ls_done_d;
      if_data_q  <= if_data_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM model, event monitor and a flat byte-array reference memory.
// Directed scenarios plus randomized loads/stores/fetches checked against the reference.
// Stalls are injected through rdy_in either in fixed windows or at random.
module tb_mem_ctrl;
  localparam int AW = 17;
  localparam int MEMSZ = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rdy = 1'b1;
  logic          clear = 1'b0;
  logic          if_valid = 1'b0;
  logic [31:0]   if_addr = '0;
  logic          if_done;
  logic [31:0]   if_data;
  logic          ls_valid = 1'b0;
  logic          ls_wr = 1'b0;
  logic [1:0]    ls_width = 2'b00;
  logic [31:0]   ls_addr = '0;
  logic [31:0]   ls_wdata = '0;
  logic          ls_done;
  logic [31:0]   ls_rdata;
  logic          ram_en;
  logic          ram_r_nw;
  logic [AW-1:0] ram_a;
  logic [7:0]    ram_d;
  logic [7:0]    ram_q = 8'h00;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  mem_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .clear_in(clear),
    .if_valid_in(if_valid), .if_addr_in(if_addr), .if_done_out(if_done), .if_data_out(if_data),
    .ls_valid_in(ls_valid), .ls_wr_in(ls_wr), .ls_width_in(ls_width), .ls_addr_in(ls_addr),
    .ls_wdata_in(ls_wdata), .ls_done_out(ls_done), .ls_rdata_out(ls_rdata),
    .ram_en_out(ram_en), .ram_r_nw_out(ram_r_nw), .ram_a_out(ram_a), .ram_d_out(ram_d),
    .ram_d_in(ram_q)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference memory (expected contents) and the physical RAM model.
  logic [7:0] ref_mem [MEMSZ];
  logic [7:0] mem [MEMSZ];
  bit mem_ready = 1'b0;

  always @(posedge clk) begin
    if (!mem_ready) begin
      mem <= ref_mem;
      mem_ready <= 1'b1;
    end else if (ram_en && !ram_r_nw) begin
      mem[ram_a] <= ram_d;
    end
    if (ram_en && ram_r_nw) ram_q <= mem[ram_a];
    else ram_q <= 8'($urandom);
  end

  typedef struct { int c; logic [AW-1:0] a; logic rnw; logic [7:0] d; } ram_ev_t;
  typedef struct { int c; logic [31:0] d; } done_ev_t;
  ram_ev_t  ram_log[$];
  done_ev_t if_log[$];
  done_ev_t ls_log[$];
  ram_ev_t  mon_r;
  done_ev_t mon_d;

  always @(negedge clk) begin
    if (ram_en) begin
      mon_r.c = cyc; mon_r.a = ram_a; mon_r.rnw = ram_r_nw; mon_r.d = ram_d;
      ram_log.push_back(mon_r);
    end
    if (if_done) begin mon_d.c = cyc; mon_d.d = if_data; if_log.push_back(mon_d); end
    if (ls_done) begin mon_d.c = cyc; mon_d.d = ls_rdata; ls_log.push_back(mon_d); end
  end

  function automatic int ram_count(input int lo, input int hi);
    int n = 0;
    foreach (ram_log[i]) if (ram_log[i].c >= lo && ram_log[i].c <= hi) n++;
    return n;
  endfunction

  // {address, r_nw, data} issued in cycle c, or all-X if the RAM was idle.
  function automatic logic [AW+8:0] ram_ev_at(input int c);
    foreach (ram_log[i]) if (ram_log[i].c == c) return {ram_log[i].a, ram_log[i].rnw, ram_log[i].d};
    return 'x;
  endfunction

  function automatic int done_count(input bit is_if, input int lo, input int hi);
    int n = 0;
    if (is_if) begin foreach (if_log[i]) if (if_log[i].c >= lo && if_log[i].c <= hi) n++; end
    else begin foreach (ls_log[i]) if (ls_log[i].c >= lo && ls_log[i].c <= hi) n++; end
    return n;
  endfunction

  function automatic int nbytes(input logic [1:0] w);
    return (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [AW-1:0] wrap_addr(input logic [31:0] a, input int k);
    logic [31:0] s;
    s = a + 32'(k);
    return s[AW-1:0];
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a, input int n);
    logic [31:0] r = '0;
    for (int k = 0; k < n; k++) r = r | (32'(ref_mem[wrap_addr(a, k)]) << (8 * k));
    return r;
  endfunction

  function automatic void ref_write(input logic [31:0] a, input logic [31:0] d, input int n);
    for (int k = 0; k < n; k++) ref_mem[wrap_addr(a, k)] = 8'(d >> (8 * k));
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Drives one request until its done pulse. mode: 0 no stall, 1 random stalls, 2 stall window [s_lo,s_hi].
  task automatic do_req(input bit is_if, input bit wr, input logic [1:0] w, input logic [31:0] addr,
                        input logic [31:0] wd, input int mode, input int s_lo, input int s_hi,
                        output int c0, output int cd, output logic [31:0] rd, output bit tmo);
    bit got = 1'b0;
    c0 = cyc; cd = -1; rd = 'x;
    if (is_if) begin if_valid = 1'b1; if_addr = addr; end
    else begin ls_valid = 1'b1; ls_wr = wr; ls_width = w; ls_addr = addr; ls_wdata = wd; end
    for (int i = 0; i < 100 && !got; i++) begin
      if (mode == 1) rdy = ($urandom_range(0, 3) != 0);
      else if (mode == 2) rdy = !(cyc >= c0 + s_lo && cyc <= c0 + s_hi);
      else rdy = 1'b1;
      @(negedge clk);
      if (is_if ? if_done : ls_done) begin got = 1'b1; cd = cyc; rd = is_if ? if_data : ls_rdata; end
      step();
    end
    tmo = !got;
    if_valid = 1'b0; ls_valid = 1'b0; rdy = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step();
    @(negedge clk);
    tests_run++; if (if_done !== 1'b0) begin tests_failed++; $display("FAIL reset_if_done got %b want 0", if_done); end
    tests_run++; if (ls_done !== 1'b0) begin tests_failed++; $display("FAIL reset_ls_done got %b want 0", ls_done); end
    tests_run++; if (if_data !== 32'h0) begin tests_failed++; $display("FAIL reset_if_data got %h want 0", if_data); end
    tests_run++; if (ls_rdata !== 32'h0) begin tests_failed++; $display("FAIL reset_ls_rdata got %h want 0", ls_rdata); end
    tests_run++; if (ram_en !== 1'b0) begin tests_failed++; $display("FAIL reset_ram_en got %b want 0", ram_en); end
    tests_run++; if (ram_r_nw !== 1'b1) begin tests_failed++; $display("FAIL reset_ram_r_nw got %b want 1", ram_r_nw); end
    tests_run++; if (ram_a !== '0) begin tests_failed++; $display("FAIL reset_ram_a got %h want 0", ram_a); end
    tests_run++; if (ram_d !== 8'h0) begin tests_failed++; $display("FAIL reset_ram_d got %h want 0", ram_d); end
    step(); rst = 1'b0; step();
  endtask

  task automatic test_fetch();
    int c0, cd; logic [31:0] rd; bit tmo;
    logic [AW-1:0] ea;
    do_req(1'b1, 1'b0, 2'b00, 32'h100, 32'h0, 0, 0, 0, c0, cd, rd, tmo);
    tests_run++; if (tmo) begin tests_failed++; $display("FAIL fetch_timeout got no done want done"); end
    tests_run++; if (cd - c0 !== 5) begin tests_failed++; $display("FAIL fetch_latency got %0d want 5", cd - c0); end
    tests_run++; if (rd !== 32'h12345678) begin tests_failed++; $display("FAIL fetch_data got %h want 12345678", rd); end
    tests_run++; if (ram_count(c0, c0 + 5) !== 4) begin tests_failed++; $display("FAIL fetch_ram_busy got %0d want 4", ram_count(c0, c0 + 5)); end
    for (int k = 0; k < 4; k++) begin
      ea = AW'(32'h100 + k);
      tests_run++;
      if (ram_ev_at(c0 + k) !== {ea, 1'b1, 8'h00}) begin
        tests_failed++; $display("FAIL fetch_byte%0d got %h want %h", k, ram_ev_at(c0 + k), {ea, 1'b1, 8'h00});
      end
    end
  endtask

  task automatic test_store_load();
    int c0, cd; logic [31:0] rd; bit tmo;
    logic [AW-1:0] ea; logic [31:0] wd;
    wd = 32'hDEADBEEF;
    do_req(1'b0, 1'b1, 2'b10, 32'h200, wd, 0, 0, 0, c0, cd, rd, tmo);
    ref_write(32'h200, wd, 4);
    tests_run++; if (tmo || cd - c0 !== 4) begin tests_failed++; $display("FAIL store_latency got %0d want 4", cd - c0); end
    for (int k = 0; k < 4; k++) begin
      ea = AW'(32'h200 + k);
      tests_run++;
      if (ram_ev_at(c0 + k) !== {ea, 1'b0, 8'(wd >> (8 * k))}) begin
        tests_failed++; $display("FAIL store_byte%0d got %h want %h", k, ram_ev_at(c0 + k), {ea, 1'b0, 8'(wd >> (8 * k))});
      end
    end
    do_req(1'b0, 1'b0, 2'b01, 32'h202, 32'h0, 0, 0, 0, c0, cd, rd, tmo);
    tests_run++; if (tmo || cd - c0 !== 3) begin tests_failed++; $display("FAIL loadh_latency got %0d want 3", cd - c0); end
    tests_run++; if (rd !== 32'h0000DEAD) begin tests_failed++; $display("FAIL loadh_data got %h want 0000dead", rd); end
    tests_run++; if (if_data !== 32'h12345678) begin tests_failed++; $display("FAIL if_data_hold got %h want 12345678", if_data); end
  endtask

  task automatic test_back_to_back();
    int c0, ls_cd, if_cd; logic [31:0] ls_d, if_d;
    logic [AW-1:0] ea;
    c0 = cyc; ls_cd = -1; if_cd = -1; ls_d = 'x; if_d = 'x;
    if_valid = 1'b1; if_addr = 32'h10;
    ls_valid = 1'b1; ls_wr = 1'b0; ls_width = 2'b00; ls_addr = 32'h20;
    for (int i = 0; i < 40 && if_cd < 0; i++) begin
      @(negedge clk);
      if (ls_done && ls_cd < 0) begin ls_cd = cyc; ls_d = ls_rdata; end
      if (if_done) begin if_cd = cyc; if_d = if_data; end
      step();
      if (ls_cd >= 0) ls_valid = 1'b0;
    end
    if_valid = 1'b0; ls_valid = 1'b0;
    ea = AW'(32'h10);
    tests_run++; if (ls_cd - c0 !== 2) begin tests_failed++; $display("FAIL arb_ls_latency got %0d want 2", ls_cd - c0); end
    tests_run++; if (ls_d !== ref_read(32'h20, 1)) begin tests_failed++; $display("FAIL arb_ls_data got %h want %h", ls_d, ref_read(32'h20, 1)); end
    tests_run++; if (ram_ev_at(c0 + 2) !== {ea, 1'b1, 8'h00}) begin tests_failed++; $display("FAIL arb_if_accept got %h want %h", ram_ev_at(c0 + 2), {ea, 1'b1, 8'h00}); end
    tests_run++; if (if_cd - c0 !== 7) begin tests_failed++; $display("FAIL arb_if_latency got %0d want 7", if_cd - c0); end
    tests_run++; if (if_d !== ref_read(32'h10, 4)) begin tests_failed++; $display("FAIL arb_if_data got %h want %h", if_d, ref_read(32'h10, 4)); end
  endtask

  task automatic test_clear();
    int c0, cd; logic [31:0] rd; bit tmo;
    c0 = cyc;
    if_valid = 1'b1; if_addr = 32'h300;
    step(); step();
    clear = 1'b1; if_valid = 1'b0;
    step();
    clear = 1'b0;
    repeat (5) step();
    tests_run++; if (done_count(1'b1, c0, cyc) !== 0) begin tests_failed++; $display("FAIL clear_no_done got %0d want 0", done_count(1'b1, c0, cyc)); end
    tests_run++; if (ram_count(c0 + 2, c0 + 4) !== 0) begin tests_failed++; $display("FAIL clear_ram_idle got %0d want 0", ram_count(c0 + 2, c0 + 4)); end
    do_req(1'b1, 1'b0, 2'b00, 32'h340, 32'h0, 0, 0, 0, c0, cd, rd, tmo);
    tests_run++; if (tmo || cd - c0 !== 5) begin tests_failed++; $display("FAIL clear_refetch_latency got %0d want 5", cd - c0); end
    tests_run++; if (rd !== ref_read(32'h340, 4)) begin tests_failed++; $display("FAIL clear_refetch_data got %h want %h", rd, ref_read(32'h340, 4)); end
  endtask

  task automatic test_stall();
    int c0, cd; logic [31:0] rd; bit tmo;
    logic [AW-1:0] ea;
    do_req(1'b0, 1'b0, 2'b10, 32'h400, 32'h0, 2, 2, 3, c0, cd, rd, tmo);
    ea = AW'(32'h401);
    tests_run++; if (tmo || cd - c0 !== 8) begin tests_failed++; $display("FAIL stall_latency got %0d want 8", cd - c0); end
    tests_run++; if (rd !== ref_read(32'h400, 4)) begin tests_failed++; $display("FAIL stall_data got %h want %h", rd, ref_read(32'h400, 4)); end
    tests_run++; if (ram_count(c0 + 2, c0 + 3) !== 0) begin tests_failed++; $display("FAIL stall_ram_off got %0d want 0", ram_count(c0 + 2, c0 + 3)); end
    tests_run++; if (ram_ev_at(c0 + 4) !== {ea, 1'b1, 8'h00}) begin tests_failed++; $display("FAIL stall_reissue got %h want %h", ram_ev_at(c0 + 4), {ea, 1'b1, 8'h00}); end
    tests_run++; if (ram_count(c0, c0 + 8) !== 5) begin tests_failed++; $display("FAIL stall_issue_count got %0d want 5", ram_count(c0, c0 + 8)); end
  endtask

  task automatic test_wrap();
    int c0, cd; logic [31:0] rd; bit tmo;
    logic [AW-1:0] ea;
    do_req(1'b0, 1'b0, 2'b10, 32'h0001FFFE, 32'h0, 0, 0, 0, c0, cd, rd, tmo);
    tests_run++; if (tmo || cd - c0 !== 5) begin tests_failed++; $display("FAIL wrap_latency got %0d want 5", cd - c0); end
    tests_run++; if (rd !== ref_read(32'h0001FFFE, 4)) begin tests_failed++; $display("FAIL wrap_data got %h want %h", rd, ref_read(32'h0001FFFE, 4)); end
    for (int k = 0; k < 4; k++) begin
      ea = (k < 2) ? AW'(32'h1FFFE + k) : AW'(k - 2);
      tests_run++;
      if (ram_ev_at(c0 + k) !== {ea, 1'b1, 8'h00}) begin
        tests_failed++; $display("FAIL wrap_byte%0d got %h want %h", k, ram_ev_at(c0 + k), {ea, 1'b1, 8'h00});
      end
    end
  endtask

  task automatic test_reset_abort();
    int c0;
    c0 = cyc;
    ls_valid = 1'b1; ls_wr = 1'b0; ls_width = 2'b10; ls_addr = 32'h500;
    step(); step();
    rst = 1'b1; ls_valid = 1'b0;
    step();
    rst = 1'b0;
    repeat (8) step();
    tests_run++; if (done_count(1'b0, c0, cyc) !== 0) begin tests_failed++; $display("FAIL rst_abort_done got %0d want 0", done_count(1'b0, c0, cyc)); end
    tests_run++; if (ram_count(c0 + 2, cyc) !== 0) begin tests_failed++; $display("FAIL rst_abort_ram got %0d want 0", ram_count(c0 + 2, cyc)); end
  endtask

  task automatic test_random();
    int c0, cd, n, op, mode; logic [31:0] rd, addr, wd, exp; logic [1:0] w; bit tmo, is_if, wr;
    for (int t = 0; t < 60; t++) begin
      op = $urandom_range(0, 2);
      is_if = (op == 0); wr = (op == 2);
      w = 2'($urandom);
      addr = $urandom;
      addr[16:6] = ($urandom_range(0, 1) == 1) ? 11'h7FF : 11'h000;
      wd = $urandom;
      mode = ($urandom_range(0, 2) == 0) ? 1 : 0;
      n = is_if ? 4 : nbytes(w);
      exp = ref_read(addr, n);
      do_req(is_if, wr, w, addr, wd, mode, 0, 0, c0, cd, rd, tmo);
      tests_run++; if (tmo) begin tests_failed++; $display("FAIL rand%0d_timeout got no done want done", t); end
      if (wr) begin
        ref_write(addr, wd, n);
      end else begin
        tests_run++; if (rd !== exp) begin tests_failed++; $display("FAIL rand%0d_data got %h want %h (addr %h n %0d)", t, rd, exp, addr, n); end
      end
      if (mode == 0) begin
        tests_run++;
        if (cd - c0 !== (wr ? n : n + 1)) begin
          tests_failed++; $display("FAIL rand%0d_latency got %0d want %0d", t, cd - c0, wr ? n : n + 1);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < MEMSZ; i++) ref_mem[i] = 8'($urandom);
    ref_mem[32'h100] = 8'h78; ref_mem[32'h101] = 8'h56;
    ref_mem[32'h102] = 8'h34; ref_mem[32'h103] = 8'h12;
    test_reset();
    test_fetch();
    test_store_load();
    test_back_to_back();
    test_clear();
    test_stall();
    test_wrap();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Sits directly upstream of the byte-wide on-board RAM and is its only master.
- Arbitrates between instruction fetch (32-bit reads) and the load/store unit (1/2/4-byte reads and writes).
- Serialises each access into little-endian byte transactions against the RAM's 1-cycle synchronous read.
- Returns assembled words with a level-valid / done-pulse handshake.

Parameters:
ADDR_WIDTH, 17, RAM byte-address width; ram_a_out carries the low ADDR_WIDTH bits of the 32-bit CPU address.

Ports:
clk_in  input  1  system clock, rising edge
rst_in  input  1  synchronous reset, active-high
rdy_in  input  1  global ready; 0 freezes the block
clear_in  input  1  pipeline flush; aborts instruction fetch only
if_valid_in  input  1  fetch request, held high until if_done_out
if_addr_in  input  32  fetch byte address
if_done_out  output  1  one-cycle pulse, if_data_out valid
if_data_out  output  32  fetched word
ls_valid_in  input  1  load/store request, held until ls_done_out
ls_wr_in  input  1  1 = store, 0 = load
ls_width_in  input  2  00 byte, 01 half, 10 word, 11 treated as word
ls_addr_in  input  32  byte address
ls_wdata_in  input  32  store data, low bytes used
ls_done_out  output  1  one-cycle pulse
ls_rdata_out  output  32  load data, zero-extended
ram_en_out  output  1  RAM chip enable
ram_r_nw_out  output  1  1 read, 0 write
ram_a_out  output  ADDR_WIDTH  RAM byte address
ram_d_out  output  8  write byte
ram_d_in  input  8  read byte, valid one cycle after its address

Behaviour:
- Reset (clock edge with rst_in=1): state IDLE, counters 0.
- Reset values: if_done_out=0, ls_done_out=0, if_data_out=0, ls_rdata_out=0, ram_en_out=0, ram_r_nw_out=1, ram_a_out=0, ram_d_out=0.
- Reset mid-access abandons it; no done pulse.
- States: IDLE, IF_RD, LS_RD, LS_WR.
- Arbitration in IDLE:
  - ls_valid_in beats if_valid_in.
  - A requester is not accepted in a cycle where its own done_out is high.
  - A fetch is not accepted while clear_in=1.
- Acceptance cycle = cycle 0. Byte 0 address is driven combinationally from the request in cycle 0. Byte k is issued in cycle k at address (addr+k) mod 2^ADDR_WIDTH; wrap is permitted. N = 1, 2 or 4.
- Reads:
  - Byte k is captured from ram_d_in in cycle k+1 into byte lane k.
  - Registered done plus data appear in cycle N+1; a word read completes in 5 cycles.
  - Unused upper lanes are 0.
- Writes:
  - ram_r_nw_out=0 and ram_d_out = lane k of ls_wdata_in in cycle k.
  - done appears in cycle N.
- Completion:
  - The state returns to IDLE in the done cycle.
  - The other requester may be accepted in that same cycle.
  - Data outputs hold their value until the next done for that port.
- ram_en_out is 0 in any cycle with no byte issued.
- clear_in:
  - If high during IF_RD, the fetch aborts and the next state is IDLE; no if_done_out.
  - if_done_out is masked to 0 in any cycle with clear_in=1.
  - LS accesses are never affected.
- rdy_in=0:
  - ram_en_out=0; state, counters and lanes are frozen.
  - A byte whose capture cycle falls in a stalled cycle is discarded.
  - On resume, the controller re-issues the address of the oldest uncaptured byte, then continues.
  - Write bytes already issued are not re-issued.
  - Done pulses are deferred, not dropped.
- Simultaneous fetch and load/store requests in IDLE: load/store is served, and the fetch is served at the load/store done cycle if still valid.

Decomposition:
- Shared package holds: width encodings (WIDTH_B, WIDTH_H, WIDTH_W), the state enum, and the N-from-width function.
- Flat FSM plus byte counter; no sub-module is warranted.

Test Plan:
- Memory preloaded 0x100..0x103 = 78 56 34 12; fetch 0x100 -> if_done in cycle 5, if_data_out=0x12345678, ram_en low after cycle 3.
- Store word 0xDEADBEEF at 0x200, then load half 0x202 -> write done in cycle 4, bytes EF BE AD DE; load returns 0x0000DEAD after 3 cycles.
- Fetch and load/store byte load asserted together at 0x10 and 0x20 -> load/store done first (cycle 2), fetch accepted the same cycle, fetch done 5 cycles later.
- clear_in pulsed in cycle 2 of a fetch -> no if_done_out; RAM idle next cycle; a new fetch after clear completes normally.
- rdy_in low in cycles 2–3 of a word load -> byte 1 re-issued on resume; correct word returned, done delayed by 3 cycles.
- Load word at 0x1FFFE with ADDR_WIDTH=17 -> bytes read from 0x1FFFE, 0x1FFFF, 0x00000, 0x00001.
